bcd_timer_chain: RTL

Parametrised multi-digit BCD up/down timer built from cascaded digit cells, each with its own rollover limit (e.g. 9/5/9/5 for mm:ss).
Successor to the single-digit count cell: it adds a synchronous load, a restart-to-preset, a direction select, an optional stop-at-zero mode and a registered chain carry/borrow pulse.
It sits between the 1 Hz tick generator and the display/alarm logic of the timer datapath.

---
 rtl/bcd_timer_pkg.sv | 16 +
 rtl/bcd_digit_cell.sv | 47 ++++
 rtl/bcd_timer_chain.sv | 107 ++++++++++
 3 files changed

// File: rtl/bcd_timer_pkg.sv
// rtl/bcd_timer_pkg.sv - shared widths, limit constants and direction enum for the BCD timer chain
package bcd_timer_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  localparam logic [BCD_W-1:0] LIMIT_SEC_ONES = 4'd9;
  localparam logic [BCD_W-1:0] LIMIT_SEC_TENS = 4'd5;
  localparam logic [BCD_W-1:0] LIMIT_HR_ONES  = 4'd9;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD digit register with its own rollover limit
module bcd_digit_cell
  import bcd_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_i,
  input  logic             dir_i,
  input  logic [BCD_W-1:0] limit_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  input  logic             restart_i,
  input  logic [BCD_W-1:0] start_val_i,
  output logic [BCD_W-1:0] q_o,
  output logic             terminal_o
);

  logic [BCD_W-1:0] q_q, q_d;

  // Up-terminal uses >= so an over-limit loaded digit wraps on its next step.
  assign terminal_o = (dir_e'(dir_i) == DIR_UP) ? (q_q >= limit_i) : (q_q == '0);
  assign q_o        = q_q;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (restart_i) begin
      q_d = start_val_i;
    end else if (step_i) begin
      if (dir_e'(dir_i) == DIR_UP) begin
        q_d = terminal_o ? '0 : q_q + 4'd1;
      end else begin
        q_d = terminal_o ? limit_i : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/bcd_timer_chain.sv
// rtl/bcd_timer_chain.sv - cascaded multi-digit BCD up/down timer with load, restart and stop-at-zero
// Optional tick prescaler enabled by defining BCD_TIMER_PRESCALE_EN.
module bcd_timer_chain
  import bcd_timer_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int STOP_AT_ZERO = 1,
  parameter int PRESCALE_DIV = 100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        count_en,
  input  logic                        dir,
  input  logic                        load_en,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
  input  logic                        restart,
  input  logic [BCD_W*NUM_DIGITS-1:0] start_value,
  input  logic [BCD_W*NUM_DIGITS-1:0] digit_limit,
  output logic [BCD_W*NUM_DIGITS-1:0] q,
  output logic                        carry_out,
  output logic                        zero,
  output logic                        running
);

  if (PRESCALE_DIV < 2) begin : g_bad_div
    $error("PRESCALE_DIV must be >= 2");
  end

  logic [NUM_DIGITS-1:0] term;
  logic [NUM_DIGITS-1:0] step_en;
  logic held, accept, tick, step;
  logic carry_q, carry_d, running_q, running_d;

  assign zero   = (q == '0);
  assign held   = (STOP_AT_ZERO != 0) && (dir_e'(dir) == DIR_DOWN) && zero;
  assign accept = count_en && !load_en && !restart && !held;

`ifdef BCD_TIMER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE_DIV);
  logic [PW-1:0] pre_q, pre_d;

  assign tick = (pre_q == PW'(PRESCALE_DIV - 1));

  always_comb begin
    pre_d = pre_q;
    if (load_en || restart) begin
      pre_d = '0;
    end else if (count_en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign step = accept && tick;

  // Only the enable links digits: digit i steps when all lower digits are terminal.
  always_comb begin
    step_en = '0;
    step_en[0] = step;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      step_en[i] = step_en[i-1] && term[i-1];
    end
  end

  assign carry_d   = step && (&term);
  assign running_d = accept;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .step_i      (step_en[i]),
      .dir_i       (dir),
      .limit_i     (digit_limit[BCD_W*i +: BCD_W]),
      .load_i      (load_en),
      .load_val_i  (load_value[BCD_W*i +: BCD_W]),
      .restart_i   (restart),
      .start_val_i (start_value[BCD_W*i +: BCD_W]),
      .q_o         (q[BCD_W*i +: BCD_W]),
      .terminal_o  (term[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      carry_q   <= carry_d;
      running_q <= running_d;
    end
  end

  assign carry_out = carry_q;
  assign running   = running_q;

endmodule
